// File: rtl/count_stream_checker_if.sv
// Port bundle between a count-stream source and count_stream_checker.
// FIRST_ERR_CAPTURE_EN adds the first-error capture outputs.
interface count_stream_checker_if #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    logic              ena;
    logic [DATA_W-1:0] sample_in;
    logic              sample_vld;
    logic              clear;
    logic              locked;
    logic              lost;
    logic              mismatch;
    logic [ERR_W-1:0]  err_count;
    logic [DATA_W-1:0] last_sample;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [DATA_W-1:0] first_exp;
    logic [DATA_W-1:0] first_act;
    logic              first_vld;
`endif

`ifdef FIRST_ERR_CAPTURE_EN
    modport master (
        output ena, sample_in, sample_vld, clear,
        input  locked, lost, mismatch, err_count, last_sample,
        input  first_exp, first_act, first_vld
    );
    modport slave (
        input  ena, sample_in, sample_vld, clear,
        output locked, lost, mismatch, err_count, last_sample,
        output first_exp, first_act, first_vld
    );
`else
    modport master (
        output ena, sample_in, sample_vld, clear,
        input  locked, lost, mismatch, err_count, last_sample
    );
    modport slave (
        input  ena, sample_in, sample_vld, clear,
        output locked, lost, mismatch, err_count, last_sample
    );
`endif
endinterface

// File: rtl/count_stream_checker.sv
// Lock/loss checker for an incrementing count stream with saturating error count.
// Optional FIRST_ERR_CAPTURE_EN captures expected/actual of the first error seen in LOCKED.
//
// state  | meaning
// IDLE   | waiting for the first sample to seed prev
// ACQ    | counting consecutive matches toward lock
// LOCKED | in sequence; mismatches are counted in err_count
// LOST   | lock was lost; relocking with the ACQ rules, lost stays set
module count_stream_checker #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    count_stream_checker_if.slave cs
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_N);
    localparam logic [3:0] LOSS_C = 4'(LOSS_N);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [3:0]        good_cnt_q, good_cnt_d;
    logic [3:0]        bad_cnt_q, bad_cnt_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;
    logic              mismatch_q, mismatch_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [DATA_W-1:0] last_sample_q, last_sample_d;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [DATA_W-1:0] first_exp_q, first_exp_d;
    logic [DATA_W-1:0] first_act_q, first_act_d;
    logic              first_vld_q, first_vld_d;
`endif

    logic              accept;
    logic [DATA_W-1:0] expected;
    logic              hit;

    assign accept   = cs.ena & cs.sample_vld;
    assign expected = prev_q + DATA_W'(1);
    assign hit      = (cs.sample_in == expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
            mismatch_q    <= 1'b0;
            err_count_q   <= '0;
            last_sample_q <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
            first_exp_q   <= '0;
            first_act_q   <= '0;
            first_vld_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            locked_q      <= locked_d;
            lost_q        <= lost_d;
            mismatch_q    <= mismatch_d;
            err_count_q   <= err_count_d;
            last_sample_q <= last_sample_d;
`ifdef FIRST_ERR_CAPTURE_EN
            first_exp_q   <= first_exp_d;
            first_act_q   <= first_act_d;
            first_vld_q   <= first_vld_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        locked_d      = locked_q;
        lost_d        = lost_q;
        mismatch_d    = 1'b0;
        err_count_d   = err_count_q;
        last_sample_d = last_sample_q;
`ifdef FIRST_ERR_CAPTURE_EN
        first_exp_d   = first_exp_q;
        first_act_d   = first_act_q;
        first_vld_d   = first_vld_q;
`endif

        // clear wins over a same-cycle sample; the sample is dropped entirely
        if (cs.clear) begin
            state_d     = IDLE;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
            locked_d    = 1'b0;
            lost_d      = 1'b0;
            err_count_d = '0;
`ifdef FIRST_ERR_CAPTURE_EN
            first_exp_d = '0;
            first_act_d = '0;
            first_vld_d = 1'b0;
`endif
        end else if (accept) begin
            prev_d        = cs.sample_in;
            last_sample_d = cs.sample_in;
            unique case (state_q)
                IDLE: begin
                    state_d    = ACQ;
                    good_cnt_d = '0;
                end
                ACQ, LOST: begin
                    if (hit) begin
                        if (good_cnt_q + 4'd1 == LOCK_C) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            locked_d   = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                    end else begin
                        good_cnt_d = '0;
                        mismatch_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        bad_cnt_d = '0;
                    end else begin
                        mismatch_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
`ifdef FIRST_ERR_CAPTURE_EN
                        if (!first_vld_q) begin
                            first_exp_d = expected;
                            first_act_d = cs.sample_in;
                            first_vld_d = 1'b1;
                        end
`endif
                        if (bad_cnt_q + 4'd1 == LOSS_C) begin
                            state_d    = LOST;
                            lost_d     = 1'b1;
                            locked_d   = 1'b0;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cs.locked      = locked_q;
    assign cs.lost        = lost_q;
    assign cs.mismatch    = mismatch_q;
    assign cs.err_count   = err_count_q;
    assign cs.last_sample = last_sample_q;
`ifdef FIRST_ERR_CAPTURE_EN
    assign cs.first_exp   = first_exp_q;
    assign cs.first_act   = first_act_q;
    assign cs.first_vld   = first_vld_q;
`endif

endmodule
